// File: rtl/vga_bram_pixel_fetch_pkg.sv
// ============================================================================
// Module : vga_bram_pixel_fetch_pkg
// Brief  : Shared VGA timing constants and pixel-pipeline types.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_bram_pixel_fetch_pkg;

    localparam int P_WIDTH      = 11;
    localparam int H_ACT        = 640;
    localparam int H_FP         = 16;
    localparam int H_SYNC       = 96;
    localparam int H_BP         = 48;
    localparam int V_ACT        = 480;
    localparam int V_FP         = 10;
    localparam int V_SYNC       = 2;
    localparam int V_BP         = 33;
    localparam int PIX_PER_WORD = 2;
    localparam int PIX_BITS     = 12;

    // Per-pixel control bits that travel alongside the BRAM read.
    typedef struct packed {
        logic hs;
        logic vs;
        logic valid;
        logic odd;
    } pix_tag_t;

    localparam pix_tag_t TAG_RST = '{hs: 1'b1, vs: 1'b1, valid: 1'b0, odd: 1'b0};

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

endpackage

`default_nettype wire

// File: rtl/vga_delay_line.sv
// ============================================================================
// Module : vga_delay_line
// Brief  : Shift register of DEPTH stages with an asynchronous per-bit reset value.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_delay_line #(
    parameter int               WIDTH   = 4,
    parameter int               DEPTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= RST_VAL;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/vga_bram_pixel_fetch.sv
// ============================================================================
// Module : vga_bram_pixel_fetch
// Brief  : Fetches RGB444 pixel pairs from BRAM and emits latency-aligned VGA pins.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_bram_pixel_fetch
    import vga_bram_pixel_fetch_pkg::*;
#(
    parameter int ADDR_W = 18,
    parameter int RD_LAT = 2
) (
    input  logic              VGA_CLK,
    input  logic              VGA_RST,
    input  logic              HS_IN,
    input  logic              VS_IN,
    input  logic              valid_in,
    input  logic [P_WIDTH-1:0] X_in,
    input  logic [P_WIDTH-1:0] Y_in,
    input  logic [ADDR_W-1:0] FB_BASE,
    output logic              BRAM_EN,
    output logic [ADDR_W-1:0] BRAM_ADDR,
    input  logic [31:0]       BRAM_DOUT,
    output logic [3:0]        VGA_R,
    output logic [3:0]        VGA_G,
    output logic [3:0]        VGA_B,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              frame_start
);

    logic              r_vs_d;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_offset;
    logic              r_bram_en;
    logic [ADDR_W-1:0] r_bram_addr;
    logic [11:0]       r_word_odd;
    rgb444_t           r_rgb;
    logic              r_hs;
    logic              r_vs;
    logic              w_vs_fall;
    pix_tag_t          w_tag;
    logic              w_unused;

    // Gated by reset so no spurious pulse escapes while the edge detector is forced.
    assign w_vs_fall = r_vs_d & ~VS_IN & ~VGA_RST;

    always_ff @(posedge VGA_CLK or posedge VGA_RST) begin
        if (VGA_RST) begin
            r_vs_d <= 1'b1;
            r_base <= '0;
        end else begin
            r_vs_d <= VS_IN;
            if (w_vs_fall) begin
                r_base <= FB_BASE;
            end
        end
    end

    // Counts pixel pairs within the frame; the vsync clear takes priority.
    always_ff @(posedge VGA_CLK or posedge VGA_RST) begin
        if (VGA_RST) begin
            r_offset <= '0;
        end else if (!VS_IN) begin
            r_offset <= '0;
        end else if (valid_in && X_in[0]) begin
            r_offset <= r_offset + 1'b1;
        end
    end

    always_ff @(posedge VGA_CLK or posedge VGA_RST) begin
        if (VGA_RST) begin
            r_bram_en   <= 1'b0;
            r_bram_addr <= '0;
        end else begin
            r_bram_en   <= valid_in & ~X_in[0];
            r_bram_addr <= r_base + r_offset;
        end
    end

    vga_delay_line #(
        .WIDTH   (4),
        .DEPTH   (RD_LAT + 1),
        .RST_VAL (TAG_RST)
    ) u_tag_dly (
        .clk (VGA_CLK),
        .rst (VGA_RST),
        .i_d ({HS_IN, VS_IN, valid_in, X_in[0]}),
        .o_q (w_tag)
    );

    // Only the odd half is ever reused later, so only that half is kept.
    always_ff @(posedge VGA_CLK or posedge VGA_RST) begin
        if (VGA_RST) begin
            r_word_odd <= '0;
        end else if (w_tag.valid && !w_tag.odd) begin
            r_word_odd <= BRAM_DOUT[27:16];
        end
    end

    always_ff @(posedge VGA_CLK or posedge VGA_RST) begin
        if (VGA_RST) begin
            r_rgb <= '0;
            r_hs  <= 1'b1;
            r_vs  <= 1'b1;
        end else begin
            r_hs <= w_tag.hs;
            r_vs <= w_tag.vs;
            if (!w_tag.valid) begin
                r_rgb <= '0;
            end else if (!w_tag.odd) begin
                r_rgb <= BRAM_DOUT[11:0];
            end else begin
                r_rgb <= r_word_odd;
            end
        end
    end

    assign BRAM_EN     = r_bram_en;
    assign BRAM_ADDR   = r_bram_addr;
    assign VGA_R       = r_rgb.r;
    assign VGA_G       = r_rgb.g;
    assign VGA_B       = r_rgb.b;
    assign VGA_HS      = r_hs;
    assign VGA_VS      = r_vs;
    assign frame_start = w_vs_fall;

    assign w_unused = ^{Y_in, X_in[P_WIDTH-1:1], BRAM_DOUT[31:28], BRAM_DOUT[15:12]};

endmodule

`default_nettype wire

// File: tb/tb_vga_bram_pixel_fetch.sv
// ============================================================================
// Module : tb_vga_bram_pixel_fetch
// Brief  : Self-checking bench with a reduced-size raster and a BRAM model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_bram_pixel_fetch;
    import vga_bram_pixel_fetch_pkg::*;

    localparam int ADDR_W    = 18;
    localparam int RD_LAT    = 2;
    localparam int H_ACT_T   = 32;
    localparam int H_FP_T    = 4;
    localparam int H_SYNC_T  = 6;
    localparam int H_TOT_T   = 48;
    localparam int V_ACT_T   = 8;
    localparam int V_FP_T    = 2;
    localparam int V_SYNC_T  = 2;
    localparam int V_TOT_T   = 15;
    localparam int FRAME_CYC = H_TOT_T * V_TOT_T;
    localparam int WORDS     = H_ACT_T * V_ACT_T / 2;

    logic               VGA_CLK = 1'b0;
    logic               VGA_RST;
    logic               HS_IN, VS_IN, valid_in;
    logic [P_WIDTH-1:0] X_in, Y_in;
    logic [ADDR_W-1:0]  FB_BASE;
    logic               BRAM_EN;
    logic [ADDR_W-1:0]  BRAM_ADDR;
    logic [31:0]        BRAM_DOUT;
    logic [3:0]         VGA_R, VGA_G, VGA_B;
    logic               VGA_HS, VGA_VS, frame_start;

    vga_bram_pixel_fetch #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .VGA_CLK(VGA_CLK), .VGA_RST(VGA_RST), .HS_IN(HS_IN), .VS_IN(VS_IN),
        .valid_in(valid_in), .X_in(X_in), .Y_in(Y_in), .FB_BASE(FB_BASE),
        .BRAM_EN(BRAM_EN), .BRAM_ADDR(BRAM_ADDR), .BRAM_DOUT(BRAM_DOUT),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_HS(VGA_HS),
        .VGA_VS(VGA_VS), .frame_start(frame_start)
    );

    always #5 VGA_CLK = ~VGA_CLK;

    int          n_tests = 0;
    int          n_fail  = 0;
    bit          want_rst;
    bit          ones_mode;
    int unsigned seed;
    int          hc, vc;
    bit          m_prev_vs, m_ok;
    logic [ADDR_W-1:0] m_base;

    typedef struct {
        bit                hs;
        bit                vs;
        bit                valid;
        bit                even;
        bit                ok;
        bit                fs;
        logic [ADDR_W-1:0] waddr;
        logic [11:0]       pix;
    } hist_t;

    hist_t h [0:7];

    function automatic hist_t blank_entry();
        hist_t e;
        e.hs = 1'b1; e.vs = 1'b1; e.valid = 1'b0; e.even = 1'b0;
        e.ok = 1'b0; e.fs = 1'b0; e.waddr = '0; e.pix = '0;
        return e;
    endfunction

    // Frame-buffer contents: word 0 is a fixed pattern, the rest a seeded hash.
    function automatic logic [31:0] word_of(input logic [ADDR_W-1:0] a);
        if (ones_mode) return 32'hFFFF_FFFF;
        if (a == '0) return 32'h0ABC_0123;
        return (32'(a) * 32'h9E37_79B1) ^ seed;
    endfunction

    logic [31:0] r_bram_p1;
    always @(posedge VGA_CLK) begin
        r_bram_p1 <= ones_mode ? 32'hFFFF_FFFF : (BRAM_EN ? word_of(BRAM_ADDR) : $urandom);
        BRAM_DOUT <= r_bram_p1;
    end

    // One pixel clock: drive raster inputs, update the frame model, sample at negedge.
    task automatic step();
        hist_t e;
        bit    act;
        int    p;
        logic [31:0] w;
        if (h[0].fs && !want_rst) begin
            m_base = FB_BASE;
            m_ok   = 1'b1;
        end
        @(posedge VGA_CLK);
        #1;
        if (hc == H_TOT_T - 1) begin
            hc = 0;
            vc = (vc == V_TOT_T - 1) ? 0 : vc + 1;
        end else begin
            hc++;
        end
        act      = (hc < H_ACT_T) && (vc < V_ACT_T);
        VGA_RST  = want_rst;
        HS_IN    = !(hc >= H_ACT_T + H_FP_T && hc < H_ACT_T + H_FP_T + H_SYNC_T);
        VS_IN    = !(vc >= V_ACT_T + V_FP_T && vc < V_ACT_T + V_FP_T + V_SYNC_T);
        valid_in = act;
        X_in     = act ? P_WIDTH'(hc) : P_WIDTH'($urandom);
        Y_in     = P_WIDTH'(vc);
        for (int i = 7; i > 0; i--) h[i] = h[i-1];
        if (want_rst) begin
            for (int i = 0; i < 8; i++) h[i] = blank_entry();
            m_prev_vs = 1'b1;
            m_ok      = 1'b0;
            m_base    = '0;
        end else begin
            e       = blank_entry();
            e.fs    = m_prev_vs && !VS_IN;
            e.hs    = HS_IN;
            e.vs    = VS_IN;
            e.valid = act;
            e.even  = act && !X_in[0];
            e.ok    = m_ok;
            p       = vc * H_ACT_T + hc;
            e.waddr = m_base + ADDR_W'(p / 2);
            w       = word_of(e.waddr);
            e.pix   = (p % 2 == 1) ? w[27:16] : w[11:0];
            h[0]    = e;
            m_prev_vs = VS_IN;
        end
        @(negedge VGA_CLK);
    endtask

    task automatic run_until_fs(output bit hit);
        int guard = 0;
        hit = 1'b0;
        while (!hit && guard < 2 * FRAME_CYC) begin
            step();
            guard++;
            hit = h[0].fs;
        end
    endtask

    task automatic test_reset();
        int guard = 0;
        bit hit;
        while (!(vc == 3 && hc == 10) && guard < 2 * FRAME_CYC) begin
            step();
            guard++;
        end
        want_rst = 1'b1;
        repeat (5) begin
            step();
            n_tests++;
            if ({VGA_R, VGA_G, VGA_B} !== 12'h000) begin
                n_fail++;
                $display("FAIL reset_rgb: got %h expected 000", {VGA_R, VGA_G, VGA_B});
            end
            n_tests++;
            if ({VGA_HS, VGA_VS} !== 2'b11) begin
                n_fail++;
                $display("FAIL reset_sync: got %b expected 11", {VGA_HS, VGA_VS});
            end
            n_tests++;
            if ({BRAM_EN, BRAM_ADDR, frame_start} !== '0) begin
                n_fail++;
                $display("FAIL reset_bram: got en=%b addr=%h fs=%b expected all 0",
                         BRAM_EN, BRAM_ADDR, frame_start);
            end
        end
        want_rst = 1'b0;
        hit = 1'b0;
        guard = 0;
        while (!hit && guard < 2 * FRAME_CYC) begin
            step();
            guard++;
            hit = h[0].fs;
            n_tests++;
            if (frame_start !== hit) begin
                n_fail++;
                $display("FAIL reset_frame_start: got %b expected %b", frame_start, hit);
            end
        end
        n_tests++;
        if (!hit) begin
            n_fail++;
            $display("FAIL reset_vs_timeout: got no vsync edge expected one");
        end
    endtask

    task automatic test_latency();
        bit hit;
        int guard = 0;
        FB_BASE = '0;
        run_until_fs(hit);
        while (!(vc == 0 && hc == 0) && guard < 2 * FRAME_CYC) begin
            step();
            guard++;
        end
        repeat (4) step();
        n_tests++;
        if ({VGA_R, VGA_G, VGA_B} !== 12'h123) begin
            n_fail++;
            $display("FAIL latency_pix0: got %h expected 123", {VGA_R, VGA_G, VGA_B});
        end
        step();
        n_tests++;
        if ({VGA_R, VGA_G, VGA_B} !== 12'hABC) begin
            n_fail++;
            $display("FAIL latency_pix1: got %h expected abc", {VGA_R, VGA_G, VGA_B});
        end
        guard = 0;
        while (hc != H_ACT_T + H_FP_T && guard < FRAME_CYC) begin
            step();
            guard++;
        end
        repeat (3) step();
        n_tests++;
        if (VGA_HS !== 1'b1) begin
            n_fail++;
            $display("FAIL latency_hs_early: got %b expected 1", VGA_HS);
        end
        step();
        n_tests++;
        if (VGA_HS !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_hs: got %b expected 0", VGA_HS);
        end
    endtask

    task automatic test_addressing();
        bit hit;
        int cnt = 0;
        int guard = 0;
        FB_BASE = 18'h100;
        run_until_fs(hit);
        hit = 1'b0;
        while (!hit && guard < 2 * FRAME_CYC) begin
            step();
            guard++;
            n_tests++;
            if (BRAM_EN !== h[1].even) begin
                n_fail++;
                $display("FAIL addr_en: got %b expected %b", BRAM_EN, h[1].even);
            end
            if (BRAM_EN === 1'b1) begin
                n_tests++;
                if (BRAM_ADDR !== ADDR_W'(32'h100 + cnt)) begin
                    n_fail++;
                    $display("FAIL addr_seq: got %h expected %h", BRAM_ADDR, ADDR_W'(32'h100 + cnt));
                end
                cnt++;
            end
            hit = h[0].fs;
        end
        n_tests++;
        if (cnt != WORDS) begin
            n_fail++;
            $display("FAIL addr_count: got %0d reads expected %0d", cnt, WORDS);
        end
    endtask

    task automatic test_double_buffer();
        bit hit;
        int cnt = 0;
        int guard = 0;
        FB_BASE = '0;
        run_until_fs(hit);
        hit = 1'b0;
        while (!hit && guard < 2 * FRAME_CYC) begin
            step();
            guard++;
            if (vc == V_ACT_T / 2 && hc == 0) FB_BASE = 18'h20000;
            if (BRAM_EN === 1'b1) begin
                n_tests++;
                if (BRAM_ADDR !== ADDR_W'(cnt)) begin
                    n_fail++;
                    $display("FAIL dbuf_old_base: got %h expected %h", BRAM_ADDR, ADDR_W'(cnt));
                end
                cnt++;
            end
            hit = h[0].fs;
        end
        guard = 0;
        do begin
            step();
            guard++;
        end while (BRAM_EN !== 1'b1 && guard < 2 * FRAME_CYC);
        n_tests++;
        if ({BRAM_EN, BRAM_ADDR} !== {1'b1, 18'h20000}) begin
            n_fail++;
            $display("FAIL dbuf_new_base: got en=%b addr=%h expected en=1 addr=20000", BRAM_EN, BRAM_ADDR);
        end
    endtask

    task automatic test_wrap();
        bit hit;
        int guard = 0;
        FB_BASE = 18'h3FFFF;
        run_until_fs(hit);
        do begin
            step();
            guard++;
        end while (BRAM_EN !== 1'b1 && guard < 2 * FRAME_CYC);
        n_tests++;
        if ({BRAM_EN, BRAM_ADDR} !== {1'b1, 18'h3FFFF}) begin
            n_fail++;
            $display("FAIL wrap_first: got en=%b addr=%h expected en=1 addr=3ffff", BRAM_EN, BRAM_ADDR);
        end
        guard = 0;
        do begin
            step();
            guard++;
        end while (BRAM_EN !== 1'b1 && guard < FRAME_CYC);
        n_tests++;
        if ({BRAM_EN, BRAM_ADDR} !== {1'b1, 18'h00000}) begin
            n_fail++;
            $display("FAIL wrap_second: got en=%b addr=%h expected en=1 addr=00000", BRAM_EN, BRAM_ADDR);
        end
    endtask

    task automatic test_blanking();
        bit hit;
        logic [11:0] exp_rgb;
        run_until_fs(hit);
        ones_mode = 1'b1;
        repeat (FRAME_CYC) begin
            step();
            exp_rgb = h[4].valid ? 12'hFFF : 12'h000;
            n_tests++;
            if ({VGA_R, VGA_G, VGA_B} !== exp_rgb) begin
                n_fail++;
                $display("FAIL blank_rgb: got %h expected %h (v=%0d h=%0d)", {VGA_R, VGA_G, VGA_B}, exp_rgb, vc, hc);
            end
        end
        ones_mode = 1'b0;
    endtask

    task automatic test_random();
        repeat (4 * FRAME_CYC) begin
            if ($urandom_range(0, 199) == 0) FB_BASE = ADDR_W'($urandom);
            step();
            n_tests++;
            if ({VGA_HS, VGA_VS} !== {h[4].hs, h[4].vs}) begin
                n_fail++;
                $display("FAIL rand_sync: got %b expected %b", {VGA_HS, VGA_VS}, {h[4].hs, h[4].vs});
            end
            if (!h[4].valid || h[4].ok) begin
                n_tests++;
                if ({VGA_R, VGA_G, VGA_B} !== (h[4].valid ? h[4].pix : 12'h000)) begin
                    n_fail++;
                    $display("FAIL rand_rgb: got %h expected %h", {VGA_R, VGA_G, VGA_B},
                             h[4].valid ? h[4].pix : 12'h000);
                end
            end
            n_tests++;
            if (BRAM_EN !== h[1].even) begin
                n_fail++;
                $display("FAIL rand_en: got %b expected %b", BRAM_EN, h[1].even);
            end
            if (h[1].even && h[1].ok) begin
                n_tests++;
                if (BRAM_ADDR !== h[1].waddr) begin
                    n_fail++;
                    $display("FAIL rand_addr: got %h expected %h", BRAM_ADDR, h[1].waddr);
                end
            end
            n_tests++;
            if (frame_start !== h[0].fs) begin
                n_fail++;
                $display("FAIL rand_frame_start: got %b expected %b", frame_start, h[0].fs);
            end
        end
    endtask

    initial begin
        seed      = $urandom;
        hc        = H_TOT_T - 1;
        vc        = V_ACT_T + V_FP_T - 2;
        for (int i = 0; i < 8; i++) h[i] = blank_entry();
        m_prev_vs = 1'b1;
        m_ok      = 1'b0;
        m_base    = '0;
        ones_mode = 1'b0;
        want_rst  = 1'b1;
        VGA_RST   = 1'b1;
        HS_IN     = 1'b1;
        VS_IN     = 1'b1;
        valid_in  = 1'b0;
        X_in      = '0;
        Y_in      = '0;
        FB_BASE   = '0;
        repeat (3) step();
        want_rst = 1'b0;

        test_reset();
        test_latency();
        test_addressing();
        test_double_buffer();
        test_wrap();
        test_blanking();
        test_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vga_bram_pixel_fetch.md
# vga_bram_pixel_fetch

Pixel-fetch stage directly downstream of the VGA sync generator. Consumes the generator's `VGA_HS`/`VGA_VS`/`valid`/`X`/`Y`, reads the frame buffer from a BRAM port (two RGB444 pixels per 32-bit word), and drives the registered VGA pins. Sync and blanking are delayed to match BRAM read latency, so colour and sync leave the block aligned.

## Interface

Parameters:
- `ADDR_W`, 18: BRAM word-address width. 640×480/2 = 153600 words.
- `RD_LAT`, 2: BRAM read latency in cycles, counted from `BRAM_EN`/`BRAM_ADDR` to valid `BRAM_DOUT`. Legal range is 1–4.

Ports (the clock is `VGA_CLK`; the reset is `VGA_RST`, asynchronous and active-high):
- `VGA_CLK` in 1: pixel clock.
- `VGA_RST` in 1: asynchronous, active-high reset.
- `HS_IN` in 1: sync-generator horizontal sync, active low.
- `VS_IN` in 1: sync-generator vertical sync, active low.
- `valid_in` in 1: active-area flag from the sync generator.
- `X_in` in `` `P_WIDTH``: active-area column.
- `Y_in` in `` `P_WIDTH``: active-area row. Informational only.
- `FB_BASE` in `ADDR_W`: frame-buffer base word address. Software/double-buffer controlled.
- `BRAM_EN` out 1: read enable.
- `BRAM_ADDR` out `ADDR_W`: read word address.
- `BRAM_DOUT` in 32: read data. `[15:0]` is the even pixel and `[31:16]` is the odd pixel; each is RGB444 in bits `[11:0]` of its half.
- `VGA_R` out 4: red, registered.
- `VGA_G` out 4: green, registered.
- `VGA_B` out 4: blue, registered.
- `VGA_HS` out 1: delayed horizontal sync, active low.
- `VGA_VS` out 1: delayed vertical sync, active low.
- `frame_start` out 1: one-cycle pulse when the frame base is latched.

## Operation

- **Base latch.** `base_l <= FB_BASE` on the cycle `VS_IN` goes 1→0 (detected with a registered `VS_IN`). `frame_start` pulses that same cycle. A mid-frame change of `FB_BASE` is ignored until the next vsync.
- **Offset counter** (`ADDR_W` bits):
  - cleared while `VS_IN`=0;
  - increments by 1 on each cycle with `valid_in`=1 and `X_in[0]`=1;
  - wraps modulo 2^`ADDR_W`.
- **Read issue.**
  - `BRAM_EN` = registered (`valid_in` && `X_in[0]`=0).
  - `BRAM_ADDR` = registered (`base_l` + offset), also mod 2^`ADDR_W`.
  - A read therefore occurs once per pixel pair.
- **Delay line.** `{HS_IN, VS_IN, valid_in, X_in[0]}` pass through a shift register of depth `RD_LAT`+1 (the +1 is the address register).
- **Word capture.** When the delayed even-pixel flag is set, `word_r <= BRAM_DOUT`.
- **Pixel select.** The output register loads:
  - even pixel: `BRAM_DOUT[11:0]`;
  - odd pixel: `word_r[27:16]`;
  - no delayed `valid`: 0 (blanking).
- **Unpaired odd pixel.** An odd pixel without a preceding even read outputs stale `word_r`. This is not an error.
- **Constraint.** `` `H_ACT`` must be even.

## Timing

- Input-to-pin latency is `RD_LAT`+2 cycles for RGB, `VGA_HS`, and `VGA_VS` alike (address register + BRAM + output register).
- The BRAM read for pixel pair k is issued 1 cycle after its even pixel appears at the inputs.
- Reset values, forced asynchronously while `VGA_RST`=1:
  - `VGA_R`/`VGA_G`/`VGA_B` = 0;
  - `VGA_HS` = `VGA_VS` = 1;
  - `BRAM_EN` = 0, `BRAM_ADDR` = 0;
  - `frame_start` = 0;
  - `base_l`, offset, `word_r`, and the delay line = 0, with delayed sync bits = 1.
- Reset mid-frame: outputs blank with sync inactive. The first correct frame begins after the next `VS_IN` falling edge.
- Simultaneous vsync edge and `valid_in`: cannot occur with legal timing. If forced, the clear wins over the increment.
- `FB_BASE` is sampled only at the `VS_IN` falling edge. No other handshake exists.

## Structure

- Timing constants (`` `P_WIDTH``, `` `H_ACT``, `` `V_ACT``, sync/back-porch values) come from the shared `vga_params.v`.
- Add `` `PIX_PER_WORD`` (2) and `` `PIX_BITS`` (12) to `vga_params.v`.
- One sub-module: `vga_delay_line` (parameters `WIDTH`, `DEPTH`; asynchronous-reset shift register with per-bit reset value). It is reused for the sync/valid/parity alignment.

## Test plan

- **Reset.** Hold `VGA_RST` for 5 cycles mid-line. Require RGB=0, `VGA_HS`=`VGA_VS`=1, `BRAM_EN`=0 throughout. Release it; the first `frame_start` coincides with the next `VS_IN` falling edge.
- **Latency.** BRAM model (`RD_LAT`=2) returns `{16'h0ABC, 16'h0123}` at `FB_BASE`=0. Pixel (0,0) appears at the pins exactly 4 cycles after its input cycle as R=1, G=2, B=3. The next cycle shows R=A, G=B, B=C. `VGA_HS` is delayed by the same 4 cycles.
- **Addressing.** With `FB_BASE`=0x100 on a full 640×480 frame:
  - row 0 reads 0x100–0x23F;
  - row 1 starts at 0x240;
  - the last read is 0x100+153599;
  - `BRAM_EN` pulses exactly 153600 times per frame.
- **Double buffer.** Change `FB_BASE` from 0x0 to 0x20000 at line 200. The remainder of the frame still reads from the old base; the next frame's first address is 0x20000.
- **Wrap.** With `ADDR_W`=18 and `FB_BASE`=0x3FFFF, the second word address is 0x00000.
- **Blanking.** With `BRAM_DOUT` forced to 0xFFFFFFFF, RGB is 0 whenever the delayed `valid` is 0, including porches and the vsync lines.
